// File: rtl/ddr_rd_mst.sv
// ddr_rd_mst: AXI4 read master for the DDR bandwidth test.
// A command (start strobe, byte address, burst count) is expanded into
// that many fixed-length INCR bursts on the AXI read channel. At most
// MAX_OUT bursts are in flight at once. Returned data is discarded; the
// block counts beats and keeps a sticky error flag for non-OKAY responses.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   RSTART_REG          : one-cycle command strobe (ignored when busy)
//   RADDR_REG           : start byte address, low 6 bits forced to zero
//   RNBURST_REG         : burst count, bits [15:0] used
//   RIDLE_REG           : high when no command is in progress
//   m_axi_ar*           : AXI4 read address channel (master side)
//   m_axi_r*            : AXI4 read data channel (master side)
//   rbeat_cnt           : beats received since the last accepted command
//   rerr                : sticky, any RRESP != OKAY since the last command
module ddr_rd_mst #(
  parameter int ID_W      = 6,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int BURST_LEN = 8,
  parameter int MAX_OUT   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RSTART_REG,
  input  logic [31:0]       RADDR_REG,
  input  logic [31:0]       RNBURST_REG,
  output logic              RIDLE_REG,
  output logic [ID_W-1:0]   m_axi_arid,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [ID_W-1:0]   m_axi_rid,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic [31:0]       rbeat_cnt,
  output logic              rerr
);

  localparam int                OW          = $clog2(MAX_OUT) + 1;
  localparam logic [OW-1:0]     MAX_OUT_C   = OW'(MAX_OUT);
  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * 8);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [15:0] ar_left, r_left;
  logic [OW-1:0] outstanding;
  logic        cmd_go, ar_hs, r_beat, r_last_beat, last_burst_done;

  // Data and ID of returned beats and unused command bits are not needed.
  logic unused;
  assign unused = ^{m_axi_rid, m_axi_rdata, RADDR_REG[5:0], RNBURST_REG[31:16]};

  assign m_axi_arid    = '0;
  assign m_axi_arlen   = 8'(BURST_LEN - 1);
  assign m_axi_arsize  = 3'b011;
  assign m_axi_arburst = 2'b01;

  always_comb begin
    state_nxt       = state;
    RIDLE_REG       = (state == IDLE);
    m_axi_rready    = (state != IDLE);
    // arvalid cannot drop while stalled: ar_left and outstanding only
    // move towards "not valid" on a handshake.
    m_axi_arvalid   = (state == RUN) && (ar_left != '0) && (outstanding < MAX_OUT_C);
    cmd_go          = (state == IDLE) && RSTART_REG && (RNBURST_REG[15:0] != '0);
    ar_hs           = m_axi_arvalid && m_axi_arready;
    r_beat          = m_axi_rvalid && m_axi_rready;
    r_last_beat     = r_beat && m_axi_rlast;
    last_burst_done = r_last_beat && (r_left == 16'd1);
    case (state)
      IDLE:    if (cmd_go) state_nxt = RUN;
      RUN: begin
        if (last_burst_done)                 state_nxt = IDLE;
        else if (ar_hs && ar_left == 16'd1)  state_nxt = DRAIN;
      end
      DRAIN:   if (last_burst_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      m_axi_araddr <= '0;
      ar_left      <= '0;
      r_left       <= '0;
      outstanding  <= '0;
      rbeat_cnt    <= '0;
      rerr         <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cmd_go) begin
        m_axi_araddr <= ADDR_W'({RADDR_REG[31:6], 6'b0});
        ar_left      <= RNBURST_REG[15:0];
        r_left       <= RNBURST_REG[15:0];
        outstanding  <= '0;
        rbeat_cnt    <= '0;
        rerr         <= 1'b0;
      end else begin
        if (ar_hs) begin
          m_axi_araddr <= m_axi_araddr + BURST_BYTES;
          ar_left      <= ar_left - 16'd1;
        end
        if (r_beat) begin
          rbeat_cnt <= rbeat_cnt + 32'd1;
          rerr      <= rerr | (m_axi_rresp != 2'b00);
        end
        if (r_last_beat && r_left != '0) r_left <= r_left - 16'd1;
        case ({ar_hs, r_last_beat})
          2'b10:   outstanding <= outstanding + OW'(1);
          2'b01:   if (outstanding != '0) outstanding <= outstanding - OW'(1);
          default: outstanding <= outstanding;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ddr_rd_mst.sv
module tb_ddr_rd_mst;
  localparam int ID_W = 6, ADDR_W = 32, DATA_W = 64, BURST_LEN = 8, MAX_OUT = 4;
  localparam int unsigned NO_ERR = 32'hFFFF_FFFF;

  logic clk = 1'b0, rst = 1'b1;
  logic RSTART_REG = 1'b0;
  logic [31:0] RADDR_REG = '0, RNBURST_REG = '0;
  logic RIDLE_REG;
  logic [ID_W-1:0] m_axi_arid, m_axi_rid;
  logic [ADDR_W-1:0] m_axi_araddr;
  logic [7:0] m_axi_arlen;
  logic [2:0] m_axi_arsize;
  logic [1:0] m_axi_arburst, m_axi_rresp;
  logic m_axi_arvalid, m_axi_arready, m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [DATA_W-1:0] m_axi_rdata;
  logic [31:0] rbeat_cnt;
  logic rerr;

  ddr_rd_mst #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
               .BURST_LEN(BURST_LEN), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst), .RSTART_REG(RSTART_REG), .RADDR_REG(RADDR_REG),
    .RNBURST_REG(RNBURST_REG), .RIDLE_REG(RIDLE_REG),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .rbeat_cnt(rbeat_cnt), .rerr(rerr)
  );

  always #5 clk = ~clk;

  int ntests = 0, nfail = 0;

  // Slave/monitor configuration and observations
  int unsigned r_delay = 2, err_beat = NO_ERR;
  bit ar_stall = 0, r_gaps = 0;
  int unsigned cyc = 0, ar_cnt = 0, rl_cnt = 0, beat_cnt = 0, max_outst = 0;
  int unsigned stall_viol = 0, field_bad = 0, last_rl_cyc = 0, ridx = 0;
  logic [31:0] ar_q[$];
  int unsigned slv_q[$];
  bit r_hs = 0, prev_stall = 0;
  logic [31:0] prev_addr = '0;

  // Monitor on the falling edge (sees the handshakes the next rising edge
  // will complete), slave drives just after the rising edge.
  initial begin
    int unsigned dummy;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    m_axi_rresp = 2'b00; m_axi_rid = '0; m_axi_rdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        r_hs = 0; prev_stall = 0;
      end else begin
        if (prev_stall && (!m_axi_arvalid || m_axi_araddr !== prev_addr)) stall_viol++;
        prev_stall = m_axi_arvalid && !m_axi_arready;
        prev_addr  = m_axi_araddr;
        if (m_axi_arvalid && m_axi_arready) begin
          ar_q.push_back(m_axi_araddr);
          ar_cnt++;
          if (m_axi_arlen !== 8'd7 || m_axi_arsize !== 3'd3 ||
              m_axi_arburst !== 2'd1 || m_axi_arid !== '0) field_bad++;
          slv_q.push_back(cyc + r_delay);
        end
        r_hs = m_axi_rvalid && m_axi_rready;
        if (r_hs) begin
          beat_cnt++;
          if (m_axi_rlast) begin rl_cnt++; last_rl_cyc = cyc; end
        end
        if (ar_cnt >= rl_cnt && ar_cnt - rl_cnt > max_outst) max_outst = ar_cnt - rl_cnt;
      end
      @(posedge clk); #1;
      if (rst) begin
        slv_q.delete(); ridx = 0;
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
      end else begin
        if (r_hs) begin
          ridx++;
          if (ridx == BURST_LEN) begin ridx = 0; dummy = slv_q.pop_front(); end
        end
        if (m_axi_rvalid && !r_hs) begin
          // hold the offered beat until accepted
        end else if (slv_q.size() > 0 && slv_q[0] <= cyc &&
                     (!r_gaps || $urandom_range(0, 2) != 0)) begin
          m_axi_rvalid = 1'b1;
          m_axi_rlast  = (ridx == BURST_LEN - 1);
          m_axi_rresp  = (beat_cnt == err_beat) ? 2'b10 : 2'b00;
          m_axi_rdata  = {$urandom, $urandom};
          m_axi_rid    = ID_W'($urandom);
        end else begin
          m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
        end
      end
      m_axi_arready = ar_stall ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Reference: burst i of a command goes to the 64-B aligned base + 64*i.
  function automatic int unsigned addr_errors(input logic [31:0] base, input int unsigned n);
    logic [31:0] exp;
    int unsigned bad;
    bad = (ar_q.size() == n) ? 0 : 1;
    for (int unsigned i = 0; i < n && i < ar_q.size(); i++) begin
      exp = {base[31:6], 6'b0} + 32'(64 * i);
      if (ar_q[i] !== exp) bad++;
    end
    return bad;
  endfunction

  bit done_ok, idle_after, rready_at_idle;
  int unsigned idle_cyc;

  task automatic wait_idle();
    done_ok = 0;
    for (int i = 0; i < 3000; i++) begin
      if (RIDLE_REG) begin
        done_ok = 1; idle_cyc = cyc; rready_at_idle = m_axi_rready; break;
      end
      @(posedge clk); #2;
    end
  endtask

  task automatic run_cmd(input logic [31:0] addr, input logic [31:0] n, input bit wait_done);
    ar_q.delete(); ar_cnt = 0; rl_cnt = 0; beat_cnt = 0; max_outst = 0;
    stall_viol = 0; field_bad = 0;
    @(posedge clk); #2;
    RADDR_REG = addr; RNBURST_REG = n; RSTART_REG = 1'b1;
    @(posedge clk); #2;
    RSTART_REG = 1'b0;
    idle_after = RIDLE_REG;
    if (wait_done) wait_idle();
  endtask

  task automatic test_reset();
    ntests++; if (RIDLE_REG !== 1'b1) begin nfail++; $display("FAIL reset_ridle got %b want 1", RIDLE_REG); end
    ntests++; if (m_axi_arvalid !== 1'b0 || m_axi_rready !== 1'b0) begin nfail++;
      $display("FAIL reset_valid arvalid=%b rready=%b want 0/0", m_axi_arvalid, m_axi_rready); end
    ntests++; if (rbeat_cnt !== 32'd0 || rerr !== 1'b0 || m_axi_araddr !== 32'd0) begin nfail++;
      $display("FAIL reset_regs rbeat=%0d rerr=%b araddr=%h want 0/0/0", rbeat_cnt, rerr, m_axi_araddr); end
  endtask

  task automatic test_basic();
    r_delay = 2; ar_stall = 0; r_gaps = 0; err_beat = NO_ERR;
    run_cmd(32'h1000_0000, 1, 1);
    ntests++; if (idle_after !== 1'b0) begin nfail++; $display("FAIL basic_ridle_low got %b want 0", idle_after); end
    ntests++; if (!done_ok) begin nfail++; $display("FAIL basic_timeout got busy want idle"); end
    ntests++; if (addr_errors(32'h1000_0000, 1) !== 0) begin nfail++;
      $display("FAIL basic_ar ar_count=%0d want 1 first=%h", ar_cnt, ar_q.size() ? ar_q[0] : 32'hx); end
    ntests++; if (field_bad !== 0) begin nfail++; $display("FAIL basic_fields bad=%0d want 0", field_bad); end
    ntests++; if (rbeat_cnt !== 32'd8) begin nfail++; $display("FAIL basic_beats got %0d want 8", rbeat_cnt); end
    ntests++; if (idle_cyc !== last_rl_cyc || rready_at_idle !== 1'b0) begin nfail++;
      $display("FAIL basic_idle_timing idle_cyc=%0d rlast_cyc=%0d rready=%b want equal/0", idle_cyc, last_rl_cyc, rready_at_idle); end
  endtask

  task automatic test_zero_misalign();
    bit bad = 0;
    run_cmd(32'h4000_0000, 0, 1);
    for (int i = 0; i < 10; i++) begin
      if (RIDLE_REG !== 1'b1 || m_axi_arvalid !== 1'b0) bad = 1;
      @(posedge clk); #2;
    end
    ntests++; if (bad || ar_cnt !== 0) begin nfail++; $display("FAIL zero_count ar_count=%0d bad=%0d want 0/0", ar_cnt, bad); end
    ntests++; if (rbeat_cnt !== 32'd8) begin nfail++; $display("FAIL zero_hold_beats got %0d want 8", rbeat_cnt); end
    run_cmd(32'h1234_5678, 2, 1);
    ntests++; if (!done_ok || addr_errors(32'h1234_5640, 2) !== 0) begin nfail++;
      $display("FAIL misalign_addr done=%0d count=%0d a0=%h a1=%h want 12345640/12345680", done_ok, ar_q.size(),
               ar_q.size() > 0 ? ar_q[0] : 32'hx, ar_q.size() > 1 ? ar_q[1] : 32'hx); end
  endtask

  task automatic test_throttle();
    r_delay = 20;
    run_cmd(32'h0000_0000, 10, 1);
    ntests++; if (!done_ok) begin nfail++; $display("FAIL throttle_timeout got busy want idle"); end
    ntests++; if (max_outst !== MAX_OUT) begin nfail++; $display("FAIL throttle_outst got %0d want %0d", max_outst, MAX_OUT); end
    ntests++; if (addr_errors(32'h0, 10) !== 0) begin nfail++; $display("FAIL throttle_ar count=%0d want 10", ar_cnt); end
    ntests++; if (rbeat_cnt !== 32'd80) begin nfail++; $display("FAIL throttle_beats got %0d want 80", rbeat_cnt); end
  endtask

  task automatic test_backpressure();
    logic [31:0] base;
    int unsigned n;
    ar_stall = 1; r_gaps = 1;
    for (int k = 0; k < 3; k++) begin
      base = $urandom; n = $urandom_range(3, 12); r_delay = $urandom_range(0, 5);
      run_cmd(base, n, 1);
      ntests++; if (!done_ok) begin nfail++; $display("FAIL bp_timeout run=%0d got busy want idle", k); end
      ntests++; if (stall_viol !== 0) begin nfail++; $display("FAIL bp_stable run=%0d violations=%0d want 0", k, stall_viol); end
      ntests++; if (addr_errors(base, n) !== 0) begin nfail++; $display("FAIL bp_ar run=%0d count=%0d want %0d", k, ar_cnt, n); end
      ntests++; if (rbeat_cnt !== 32'(8 * n) || max_outst > MAX_OUT) begin nfail++;
        $display("FAIL bp_beats run=%0d got %0d outst=%0d want %0d/<=%0d", k, rbeat_cnt, max_outst, 8 * n, MAX_OUT); end
    end
    ar_stall = 0; r_gaps = 0;
  endtask

  task automatic test_error_restart();
    r_delay = 3; err_beat = 13;
    run_cmd(32'h2000_0000, 3, 1);
    repeat (3) @(posedge clk); #2;
    ntests++; if (!done_ok || rerr !== 1'b1 || rbeat_cnt !== 32'd24) begin nfail++;
      $display("FAIL err_sticky done=%0d rerr=%b beats=%0d want 1/1/24", done_ok, rerr, rbeat_cnt); end
    err_beat = NO_ERR; r_delay = 4;
    run_cmd(32'h3000_0040, 4, 0);
    for (int i = 0; i < 100 && ar_cnt < 1; i++) begin @(posedge clk); #2; end
    RADDR_REG = 32'h5000_0000; RNBURST_REG = 7; RSTART_REG = 1'b1;
    @(posedge clk); #2;
    RSTART_REG = 1'b0;
    wait_idle();
    ntests++; if (!done_ok || addr_errors(32'h3000_0040, 4) !== 0) begin nfail++;
      $display("FAIL restart_ignored done=%0d count=%0d want 4", done_ok, ar_cnt); end
    ntests++; if (rerr !== 1'b0 || rbeat_cnt !== 32'd32) begin nfail++;
      $display("FAIL restart_clear rerr=%b beats=%0d want 0/32", rerr, rbeat_cnt); end
  endtask

  task automatic test_reset_midrun();
    r_delay = 6;
    run_cmd(32'h0800_0000, 10, 0);
    for (int i = 0; i < 200 && ar_cnt < 3; i++) begin @(posedge clk); #2; end
    ntests++; if (ar_cnt < 3) begin nfail++; $display("FAIL midrun_reach ar_count=%0d want 3", ar_cnt); end
    rst = 1'b1;
    @(posedge clk); #2;
    ntests++; if (RIDLE_REG !== 1'b1 || m_axi_arvalid !== 1'b0 || m_axi_rready !== 1'b0) begin nfail++;
      $display("FAIL midrun_ctrl ridle=%b arvalid=%b rready=%b want 1/0/0", RIDLE_REG, m_axi_arvalid, m_axi_rready); end
    ntests++; if (rbeat_cnt !== 32'd0 || rerr !== 1'b0 || m_axi_araddr !== 32'd0) begin nfail++;
      $display("FAIL midrun_regs beats=%0d rerr=%b araddr=%h want 0/0/0", rbeat_cnt, rerr, m_axi_araddr); end
    rst = 1'b0;
    r_delay = 2;
    run_cmd(32'h0000_1000, 2, 1);
    ntests++; if (!done_ok || addr_errors(32'h0000_1000, 2) !== 0 || rbeat_cnt !== 32'd16) begin nfail++;
      $display("FAIL post_reset done=%0d count=%0d beats=%0d want 1/2/16", done_ok, ar_cnt, rbeat_cnt); end
  endtask

  initial begin
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #2;
    test_reset();
    test_basic();
    test_zero_misalign();
    test_throttle();
    test_backpressure();
    test_error_restart();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
